udp_payload_serializer: RTL and testbench

//   Sits directly downstream of data_concat. Takes its 72-bit output (9 bytes, 4x18-bit samples packed) and streams
//   it byte-by-byte into the UDP packet builder. Groups WORDS_PER_PKT words into one payload, flags the final byte

---
 rtl/udp_payload_serializer.sv | 132 +++++++++++++
 tb/tb_udp_payload_serializer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_payload_serializer.sv
// Serializes 72-bit words from data_concat into a valid/ready byte stream, WORDS_PER_PKT words per packet.
// Optional `SEQ_HDR_EN prefixes each packet with a 4-byte big-endian packet counter header.
module udp_payload_serializer #(
    parameter int WORDS_PER_PKT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [8:0][7:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [31:0]     pkt_cnt
);

    localparam int WCNT_W = $clog2(WORDS_PER_PKT) + 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_PKT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA
`ifdef SEQ_HDR_EN
        , HDR
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          byte_idx, byte_idx_nxt;
    logic [WCNT_W-1:0]   word_cnt, word_cnt_nxt;
    logic [31:0]         pkt_cnt_nxt;
    logic [8:0][7:0]     hold;
    logic                load;
    logic                in_fire, out_fire, last_word;

    assign last_word = (word_cnt == LAST_WORD);
    assign out_valid = (state != IDLE);
    assign out_last  = (state == DATA) && (byte_idx == 4'd0) && last_word;
    // A new word may enter only as the current word's final byte leaves, so streaming has no bubble.
    assign in_ready  = !rst && ((state == IDLE) ||
                                ((state == DATA) && (byte_idx == 4'd0) && out_ready));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        word_cnt_nxt = word_cnt;
        pkt_cnt_nxt  = pkt_cnt;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (in_fire) load = 1'b1;
            end
`ifdef SEQ_HDR_EN
            HDR: begin
                if (out_fire) begin
                    if (byte_idx == 4'd0) begin
                        state_nxt    = DATA;
                        byte_idx_nxt = 4'd8;
                    end else begin
                        byte_idx_nxt = byte_idx - 4'd1;
                    end
                end
            end
`endif
            DATA: begin
                if (out_fire) begin
                    if (byte_idx != 4'd0) begin
                        byte_idx_nxt = byte_idx - 4'd1;
                    end else begin
                        if (last_word) begin
                            word_cnt_nxt = '0;
                            pkt_cnt_nxt  = pkt_cnt + 32'd1;
                        end else begin
                            word_cnt_nxt = word_cnt + 1'b1;
                        end
                        if (in_fire) load = 1'b1;
                        else         state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt    = DATA;
            byte_idx_nxt = 4'd8;
`ifdef SEQ_HDR_EN
            // A word that opens a packet is preceded by the header.
            if ((state == IDLE) ? (word_cnt == '0) : last_word) begin
                state_nxt    = HDR;
                byte_idx_nxt = 4'd3;
            end
`endif
        end
    end

    always_comb begin
        out_data = 8'h00;
        case (state)
            DATA:    out_data = hold[byte_idx];
`ifdef SEQ_HDR_EN
            HDR:     out_data = pkt_cnt[{byte_idx[1:0], 3'b000} +: 8];
`endif
            default: out_data = 8'h00;
        endcase
    end

    // NOTE: control state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= 4'd0;
            word_cnt <= '0;
            pkt_cnt  <= 32'd0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_idx_nxt;
            word_cnt <= word_cnt_nxt;
            pkt_cnt  <= pkt_cnt_nxt;
        end
    end

    // NOTE: the holding register is pure datapath and is never read in IDLE, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) hold <= in_data;
    end

endmodule

// File: tb/tb_udp_payload_serializer.sv
// Scoreboard bench for udp_payload_serializer with WORDS_PER_PKT=2; builds with or without SEQ_HDR_EN.
module tb_udp_payload_serializer;

    localparam int WPP = 2;
`ifdef SEQ_HDR_EN
    localparam int HDR_B = 4;
`else
    localparam int HDR_B = 0;
`endif

    logic            clk;
    logic            rst;
    logic [8:0][7:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [31:0]     pkt_cnt;

    udp_payload_serializer #(.WORDS_PER_PKT(WPP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .pkt_cnt   (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    popped     = 0;
    int    tb_word    = 0;
    int    exp_pkts   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push the bytes this word must produce, header first when it opens a packet.
    task automatic expect_word(input logic [71:0] d);
        beat_t b;
`ifdef SEQ_HDR_EN
        if (tb_word == 0) begin
            for (int i = 3; i >= 0; i--) begin
                b.data = 8'(exp_pkts >> (8 * i));
                b.last = 1'b0;
                q.push_back(b);
            end
        end
`endif
        for (int i = 8; i >= 0; i--) begin
            b.data = d[i*8 +: 8];
            b.last = (i == 0) && (tb_word == WPP - 1);
            q.push_back(b);
        end
        tb_word++;
        if (tb_word == WPP) begin
            tb_word = 0;
            exp_pkts++;
        end
    endtask

    // Returns on the falling edge after the handshake, leaving in_valid high.
    task automatic send_word(input logic [71:0] d);
        int guard;
        expect_word(d);
        in_data  = d;
        in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) check("send_timeout_in_ready", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 600) begin
            @(negedge clk);
            #3;
            guard++;
        end
        check("drain_queue_empty", q.size(), 0);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        q.delete();
        tb_word   = 0;
        exp_pkts  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
        end
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
    endtask

    // Monitor: pops the scoreboard on each byte handshake and checks stall stability.
    initial begin
        beat_t      b;
        logic       stalled;
        logic [7:0] sd;
        logic       sl;
        stalled = 1'b0;
        sd      = 8'h00;
        sl      = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid_held", out_valid, 1);
                    check("stall_data_held", out_data, sd);
                    check("stall_last_held", out_last, sl);
                end
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", in_ready, 0);
                    stalled = 1'b1;
                    sd      = out_data;
                    sl      = out_last;
                end else begin
                    stalled = 1'b0;
                end
                if (out_valid && out_ready) begin
                    vectors++;
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h expected none at %0t", out_data, $time);
                    end else begin
                        b = q.pop_front();
                        check("byte_data", out_data, b.data);
                        check("byte_last", out_last, b.last);
                        popped++;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        int         p0;
        int         cyc;
        int         guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        pat       = 4'b1001;

        // Reset, then two-word packet in network order.
        do_reset();
        send_word(72'h010203040506070809);
        #1;
        check("latency_out_valid", out_valid, 1);
        check("latency_first_byte", out_data, (HDR_B != 0) ? 32'h00 : 32'h01);
        send_word(72'h111213141516171819);
        in_valid = 1'b0;
        wait_drain();
        check("order_pkt_cnt", pkt_cnt, 1);

        // Backpressure with out_ready pattern 1,0,0,1.
        do_reset();
        fork
            begin
                send_word(72'h010203040506070809);
                send_word(72'h111213141516171819);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 48; i++) begin
                    @(negedge clk);
                    out_ready = pat[i % 4];
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_pkt_cnt", pkt_cnt, 1);

        // Six words back-to-back: three packets with no idle cycles.
        do_reset();
        p0 = popped;
        fork
            begin
                for (int i = 0; i < 6; i++) send_word(72'hA0A1A2A3A4A5A6A7A0 + 72'(i));
                in_valid = 1'b0;
            end
        join_none
        guard = 0;
        do begin
            @(negedge clk);
            #3;
            guard++;
        end while (!out_valid && guard < 50);
        cyc = 1;
        while (popped < p0 + 6 * 9 + 3 * HDR_B && cyc < 400) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        check("b2b_cycles", cyc, 6 * 9 + 3 * HDR_B);
        wait fork;
        wait_drain();
        check("b2b_pkt_cnt", pkt_cnt, 3);

        // Upstream gap between the two words of a packet.
        do_reset();
        send_word(72'h212223242526272829);
        in_valid = 1'b0;
        wait_drain();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("gap_out_valid", out_valid, 0);
        end
        check("gap_pkt_cnt", pkt_cnt, 0);
        send_word(72'h313233343536373839);
        in_valid = 1'b0;
        wait_drain();
        check("gap_pkt_cnt_done", pkt_cnt, 1);

        // Reset after byte 5 of word 0, then a clean packet.
        do_reset();
        p0 = popped;
        send_word(72'h414243444546474849);
        in_valid = 1'b0;
        guard = 0;
        while (popped < p0 + HDR_B + 4 && guard < 100) begin
            @(negedge clk);
            #3;
            guard++;
        end
        check("midrst_bytes_seen", popped - p0 >= HDR_B + 4, 1);
        do_reset();
        send_word(72'h515253545556575859);
        send_word(72'h616263646566676869);
        in_valid = 1'b0;
        wait_drain();
        check("midrst_pkt_cnt", pkt_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
